// File: rtl/syst_pkg.sv
// Shared constants and the result word type for the systolic output buffer.
package syst_pkg;

    localparam int WORD_DEF  = 32;
    localparam int DEPTH_DEF = 16;
    localparam int INFL_DEF  = 32;

    typedef logic [WORD_DEF-1:0] word_t;

endpackage

// File: rtl/syst_sync_fifo.sv
// Register-file FIFO of N entries sitting behind the output head register.
// N need not be a power of two, so pointers wrap explicitly at N-1.
module syst_sync_fifo #(
    parameter int W  = 32,
    parameter int N  = 15,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]  mem_r [N];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(N - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Pointer and occupancy tracking; clear resets both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (rd_en) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({wr_en, rd_en})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_r[wr_ptr_r] <= wr_data;
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/syst_out_buffer.sv
// Result buffer with registered head, credit-based issue throttling and flush.
// Define SYST_OBUF_STATS_EN to build the drop counter and high-water mark.
module syst_out_buffer
    import syst_pkg::*;
#(
    parameter int WORD     = WORD_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int INFL_MAX = INFL_DEF,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic             res_valid_i,
    input  logic [WORD-1:0]  res_data_i,
    input  logic             flush_i,
    output logic [WORD-1:0]  data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] level_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] max_level_o
);

    localparam int FC_W  = $clog2(DEPTH);
    localparam int IF_W  = $clog2(INFL_MAX + 1);
    localparam int SUM_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

    logic             head_valid_r;
    logic [WORD-1:0]  head_data_r;
    logic [IF_W-1:0]  infl_r;
    logic             issue_ready_r;
    logic             overflow_r;

    logic [FC_W-1:0]  fifo_count_s;
    logic [WORD-1:0]  fifo_rd_data_s;
    logic [CNT_W-1:0] level_s;
    logic [CNT_W-1:0] level_nxt_s;
    logic [IF_W-1:0]  infl_nxt_s;
    logic [SUM_W-1:0] credit_sum_s;
    logic             full_s, pop_s, wr_s, drop_s, issue_s;
    logic             fifo_empty_s, head_load_s, fifo_wr_s, fifo_rd_s;

    // Handshake decode, level and credit bookkeeping. The head is only empty
    // when the FIFO is empty, so a write into an empty/popping head bypasses it.
    always_comb begin
        level_s      = CNT_W'(head_valid_r) + CNT_W'(fifo_count_s);
        full_s       = (level_s == CNT_W'(DEPTH));
        pop_s        = head_valid_r & ready_i;
        wr_s         = res_valid_i & ~full_s & ~flush_i;
        drop_s       = res_valid_i & full_s & ~flush_i;
        issue_s      = issue_valid_i & issue_ready_r;
        fifo_empty_s = (fifo_count_s == {FC_W{1'b0}});
        head_load_s  = pop_s | ~head_valid_r;
        fifo_rd_s    = head_load_s & ~fifo_empty_s & ~flush_i;
        fifo_wr_s    = wr_s & ~(head_load_s & fifo_empty_s);

        if (flush_i) begin
            level_nxt_s = {CNT_W{1'b0}};
        end else if (wr_s && !pop_s) begin
            level_nxt_s = level_s + CNT_W'(1);
        end else if (!wr_s && pop_s) begin
            level_nxt_s = level_s - CNT_W'(1);
        end else begin
            level_nxt_s = level_s;
        end

        case ({issue_s, res_valid_i})
            2'b10:   infl_nxt_s = infl_r + IF_W'(1);
            2'b01:   infl_nxt_s = (infl_r == {IF_W{1'b0}}) ? infl_r : infl_r - IF_W'(1);
            default: infl_nxt_s = infl_r;
        endcase

        credit_sum_s = SUM_W'(level_nxt_s) + SUM_W'(infl_nxt_s);
    end

    syst_sync_fifo #(
        .W  (WORD),
        .N  (DEPTH - 1),
        .CW (FC_W)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clr     (flush_i),
        .wr_en   (fifo_wr_s),
        .wr_data (res_data_i),
        .rd_en   (fifo_rd_s),
        .rd_data (fifo_rd_data_s),
        .count   (fifo_count_s)
    );

    // Head register: refilled from the FIFO first, then from the incoming result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_valid_r <= 1'b0;
            head_data_r  <= {WORD{1'b0}};
        end else if (flush_i) begin
            head_valid_r <= 1'b0;
        end else if (head_load_s) begin
            if (!fifo_empty_s) begin
                head_valid_r <= 1'b1;
                head_data_r  <= fifo_rd_data_s;
            end else if (wr_s) begin
                head_valid_r <= 1'b1;
                head_data_r  <= res_data_i;
            end else begin
                head_valid_r <= 1'b0;
            end
        end
    end

    // In-flight credits, registered issue_ready and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            infl_r        <= {IF_W{1'b0}};
            issue_ready_r <= 1'b1;
            overflow_r    <= 1'b0;
        end else begin
            infl_r        <= infl_nxt_s;
            issue_ready_r <= (credit_sum_s < SUM_W'(DEPTH));
            if (drop_s) overflow_r <= 1'b1;
        end
    end

`ifdef SYST_OBUF_STATS_EN
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] max_level_r;

    // Saturating drop counter and high-water mark; untouched by flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            drop_cnt_r  <= {CNT_W{1'b0}};
            max_level_r <= {CNT_W{1'b0}};
        end else begin
            if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            if (level_nxt_s > max_level_r) max_level_r <= level_nxt_s;
        end
    end

    assign drop_cnt_o  = drop_cnt_r;
    assign max_level_o = max_level_r;
`else
    assign drop_cnt_o  = {CNT_W{1'b0}};
    assign max_level_o = {CNT_W{1'b0}};
`endif

    assign issue_ready_o = issue_ready_r;
    assign data_o        = head_data_r;
    assign valid_o       = head_valid_r;
    assign level_o       = level_s;
    assign overflow_o    = overflow_r;

endmodule

// File: tb/tb_syst_out_buffer.sv
// Directed self-checking bench for syst_out_buffer (DEPTH=16, WORD=32).
module tb_syst_out_buffer;
    import syst_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic        res_valid_i;
    word_t       res_data_i;
    logic        flush_i;
    word_t       data_o;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  level_o;
    logic        overflow_o;
    logic [4:0]  drop_cnt_o;
    logic [4:0]  max_level_o;

    int checks   = 0;
    int failures = 0;

    syst_out_buffer dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .res_valid_i   (res_valid_i),
        .res_data_i    (res_data_i),
        .flush_i       (flush_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .level_o       (level_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o),
        .max_level_o   (max_level_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag, input logic [4:0] drops, input logic [4:0] maxl);
`ifdef SYST_OBUF_STATS_EN
        chk({tag, "_drop"}, 64'(drop_cnt_o), 64'(drops));
        chk({tag, "_max"}, 64'(max_level_o), 64'(maxl));
`else
        chk({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
        chk({tag, "_max"}, 64'(max_level_o), 64'd0);
`endif
    endtask

    initial begin
        rst_i = 1'b0; issue_valid_i = 1'b0; res_valid_i = 1'b0;
        res_data_i = 32'd0; flush_i = 1'b0; ready_i = 1'b0;
        step(); step();
        chk("rst_hold_valid", 64'(valid_o), 64'd0);
        chk("rst_hold_level", 64'(level_o), 64'd0);
        rst_i = 1'b1;
        step();
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        check_stats("rst", 5'd0, 5'd0);

        // Credit throttling: 16 issues exhaust the credits.
        issue_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) step();
        issue_valid_i = 1'b0;
        chk("credit_exhausted", 64'(issue_ready_o), 64'd0);
        res_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            res_data_i = 32'h100 + 32'(i);
            step();
        end
        res_valid_i = 1'b0;
        chk("credit_level16", 64'(level_o), 64'd16);
        chk("credit_no_ovf", 64'(overflow_o), 64'd0);
        chk("credit_ready_full", 64'(issue_ready_o), 64'd0);
        chk("credit_head", 64'(data_o), 64'h100);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("credit_ready_back", 64'(issue_ready_o), 64'd1);
        chk("credit_level15", 64'(level_o), 64'd15);
        ready_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("credit_drain", 64'(data_o), 64'h100 + 64'(i));
            step();
        end
        chk("credit_empty", 64'(valid_o), 64'd0);

        // Back-to-back results with the consumer always ready.
        res_valid_i = 1'b1;
        res_data_i = 32'hA1; step();
        chk("b2b_v1", 64'(valid_o), 64'd1);
        chk("b2b_d1", 64'(data_o), 64'hA1);
        res_data_i = 32'hA2; step();
        chk("b2b_d2", 64'(data_o), 64'hA2);
        res_data_i = 32'hA3; step();
        chk("b2b_d3", 64'(data_o), 64'hA3);
        chk("b2b_level", 64'(level_o), 64'd1);
        res_valid_i = 1'b0; step();
        chk("b2b_empty", 64'(valid_o), 64'd0);
        chk("b2b_infl_sat", 64'(issue_ready_o), 64'd1);
        ready_i = 1'b0;

        // Overflow: a result arriving while full is dropped despite a pop.
        res_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            res_data_i = 32'h200 + 32'(i);
            step();
        end
        chk("ovf_level16", 64'(level_o), 64'd16);
        chk("ovf_ready0", 64'(issue_ready_o), 64'd0);
        res_data_i = 32'hDEAD; ready_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_level15", 64'(level_o), 64'd15);
        check_stats("ovf", 5'd1, 5'd16);
        for (int i = 1; i < 16; i++) begin
            chk("ovf_drain", 64'(data_o), 64'h200 + 64'(i));
            step();
        end
        chk("ovf_empty", 64'(valid_o), 64'd0);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);
        ready_i = 1'b0;

        // Asynchronous reset mid-stream at level 7.
        res_valid_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            res_data_i = 32'h400 + 32'(i);
            step();
        end
        res_valid_i = 1'b0;
        chk("arst_level7", 64'(level_o), 64'd7);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_level", 64'(level_o), 64'd0);
        chk("arst_data", 64'(data_o), 64'd0);
        chk("arst_ovf", 64'(overflow_o), 64'd0);
        chk("arst_ready", 64'(issue_ready_o), 64'd1);
        check_stats("arst", 5'd0, 5'd0);
        step();
        rst_i = 1'b1;
        step();

        // Flush at level 5 with 3 results still in flight.
        issue_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) step();
        issue_valid_i = 1'b0;
        res_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res_data_i = 32'h300 + 32'(i);
            step();
        end
        res_valid_i = 1'b0;
        chk("fl_level5", 64'(level_o), 64'd5);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fl_level0", 64'(level_o), 64'd0);
        chk("fl_valid0", 64'(valid_o), 64'd0);
        chk("fl_ready", 64'(issue_ready_o), 64'd1);
        res_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_data_i = 32'h310 + 32'(i);
            step();
        end
        res_valid_i = 1'b0;
        chk("fl_level3", 64'(level_o), 64'd3);
        check_stats("fl", 5'd0, 5'd5);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("fl_order", 64'(data_o), 64'h310 + 64'(i));
            step();
        end
        ready_i = 1'b0;
        chk("fl_empty", 64'(valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/syst_out_buffer.md
# syst_out_buffer

Parametrised result buffer between the systolic wrapper output and the downstream consumer, replacing the fixed vendor-FIFO output stage. It stores results in an internal register-file FIFO with a registered head and standard valid/ready output handshake. A credit counter throttles issue into the array, because the systolic pipeline cannot stall. It also provides flush, occupancy reporting and overflow detection.

## Interface
- WORD, 32: result word width in bits.
- DEPTH, 16: total capacity in words, including the head register; power of two, at least 4.
- INFL_MAX, 32: maximum issues in flight inside the array; sizes the in-flight counter.
- CNT_W, $clog2(DEPTH+1): width of the level and statistics fields.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- issue_valid_i  in  1  upstream requests to push one operand set into the array.
- issue_ready_o  out  1  credit available; an issue occurs when issue_valid_i & issue_ready_o.
- res_valid_i  in  1  the array delivers one result this cycle; cannot be stalled.
- res_data_i  in  WORD  result word.
- flush_i  in  1  synchronous clear of stored words.
- data_o  out  WORD  head word.
- valid_o  out  1  data_o holds a valid word.
- ready_i  in  1  consumer accepts data_o; a pop occurs when valid_o & ready_i.
- level_o  out  CNT_W  stored words, 0..DEPTH, including the head.
- overflow_o  out  1  sticky; set when a result is dropped.
- drop_cnt_o  out  CNT_W  saturating count of dropped results; valid only with stats enabled.
- max_level_o  out  CNT_W  high-water mark of level_o; valid only with stats enabled.

## Operation
- Each issue produces exactly one result, some cycles later.
- In-flight counter: +1 on an issue, −1 on res_valid_i. Both in one cycle leaves it unchanged. A decrement at 0 saturates at 0.
- issue_ready_o = (level + inflight) < DEPTH, decoded from registers only.
- Write: res_valid_i with level < DEPTH stores res_data_i.
- The level test uses the pre-pop value. A result arriving while full is dropped even if a pop happens in the same cycle.
- Drop: overflow_o is set, and with stats enabled drop_cnt_o increments and saturates at all-ones.
- Order is strict FIFO. Storage pointers wrap modulo DEPTH−1 behind the head register.
- data_o is stable while valid_o & ~ready_i.
- Flush: level goes to 0, pointers reset and valid_o drops. A res_valid_i in the flush cycle is discarded without counting as a drop.
- Flush leaves the in-flight counter, overflow_o and the statistics unchanged.
- overflow_o clears only on reset.

## Timing
- Reset: valid_o=0, data_o=0, level_o=0, issue_ready_o=1 once reset releases, overflow_o=0, drop_cnt_o=0, max_level_o=0, in-flight counter 0.
- Reset asserted mid-operation clears everything immediately; stored data is lost.
- Write-to-output latency is 1: a result written at edge N into an empty buffer gives valid_o=1 and data_o equal to that result after edge N.
- Simultaneous pop and write at level 1: valid_o stays high and the new word appears at the next edge.
- Pop and write together at any level leave level unchanged.
- level_o, issue_ready_o and max_level_o are registered or decoded from registers; no combinational path from ready_i or res_valid_i.
- Full throughput: one write and one pop per cycle.

## Configuration
- SYST_OBUF_STATS_EN defined: drop_cnt_o and max_level_o are live registers. max_level_o updates each cycle to the maximum of itself and the next level.
- Not defined: both ports are tied to 0 and no statistics flops are synthesised. overflow_o works in both builds.

## Structure
- syst_pkg: default WORD and DEPTH constants, and a shared typedef for the result word.
- Sub-module syst_sync_fifo: register-file storage of DEPTH−1 entries with wr/rd pointers and count.
- Top level owns the head register, credit logic, flush and statistics.

## Test plan
- Reset release with no traffic -> issue_ready_o=1, valid_o=0, level_o=0.
- Issue 16 times with ready_i=0 and DEPTH=16 -> issue_ready_o drops after the 16th issue. Deliver 16 results -> level_o=16, no drop. One pop -> issue_ready_o=1 next cycle.
- Results 0xA1, 0xA2, 0xA3 written back-to-back with ready_i held 1 -> data_o shows A1, A2, A3 on consecutive cycles starting one cycle after the first write.
- Fill to 16, then inject res_valid_i=1 with pop in the same cycle -> word dropped, overflow_o=1, drop_cnt_o=1 (stats build), level_o=15.
- level_o=5 with 3 results in flight, flush_i pulsed -> level_o=0 and valid_o=0 next cycle. The 3 later results are stored normally and max_level_o is unchanged.
- Assert rst_i low mid-stream at level_o=7 -> all outputs at reset values asynchronously. Traffic resumes cleanly after release.
